// File: rtl/shift_pkg.sv
// Shared encodings for the shift engine: controller states and shift modes.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // 2'b11 is reserved and falls through to logical behaviour.
  localparam logic [1:0] MODE_LOGIC = 2'b00;
  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_ARITH = 2'b10;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step: current register, direction and mode give the next register.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [LANES-1:0] sin,
  output logic [WIDTH-1:0] next_q
);

  always_comb begin
    next_q = q;
    if (!dir) begin
      case (mode)
        MODE_ROT:   next_q = {q[LANES-1:0], q[WIDTH-1:LANES]};
        MODE_ARITH: next_q = {{LANES{q[WIDTH-1]}}, q[WIDTH-1:LANES]};
        default:    next_q = {sin, q[WIDTH-1:LANES]};
      endcase
    end else begin
      case (mode)
        MODE_ROT:   next_q = {q[WIDTH-LANES-1:0], q[WIDTH-1:WIDTH-LANES]};
        // Arithmetic left has no sign to preserve, so it zero-fills.
        MODE_ARITH: next_q = {q[WIDTH-LANES-1:0], {LANES{1'b0}}};
        default:    next_q = {q[WIDTH-LANES-1:0], sin};
      endcase
    end
  end

endmodule

// File: rtl/shift_engine.sv
// Parallel-load shift engine: takes a word, shifts it STEPS times under en, then offers the result.
module shift_engine
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic [LANES-1:0] sin,
  output logic [LANES-1:0] sout,
  output logic             sout_valid,
  output logic             cap_valid,
  input  logic             cap_ready,
  output logic [WIDTH-1:0] cap_data
);

  localparam int STEPS = WIDTH / LANES;
  localparam int CW    = $clog2(STEPS + 1);

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] next_q;
  logic [CW-1:0]    cnt;
  logic             dir_q;
  logic [1:0]       mode_q;

  shift_step #(
    .WIDTH(WIDTH),
    .LANES(LANES)
  ) u_step (
    .q      (q),
    .dir    (dir_q),
    .mode   (mode_q),
    .sin    (sin),
    .next_q (next_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      q      <= '0;
      cnt    <= '0;
      dir_q  <= 1'b0;
      mode_q <= MODE_LOGIC;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            q      <= load_data;
            dir_q  <= dir;
            mode_q <= mode;
            cnt    <= CW'(STEPS);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // The zero guard keeps the counter from wrapping even if state and count disagree.
          if (en && cnt != '0) begin
            q   <= next_q;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (cap_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign load_ready = (state == IDLE);
  assign sout_valid = (state == SHIFT);
  assign cap_valid  = (state == DONE);
  assign cap_data   = q;
  assign sout       = dir_q ? q[WIDTH-1:WIDTH-LANES] : q[LANES-1:0];

endmodule

// File: tb/tb_shift_engine.sv
// Directed bench for shift_engine: one 8x1 instance and one 8x2 instance sharing clock and reset.
module tb_shift_engine;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] load_data = '0;
  logic       dir = 1'b0;
  logic [1:0] mode = MODE_LOGIC;
  logic       en = 1'b0;
  logic       sin;
  logic       sin_drv = 1'b0;
  logic       loop = 1'b0;
  logic       sout;
  logic       sout_valid;
  logic       cap_valid;
  logic       cap_ready = 1'b0;
  logic [7:0] cap_data;

  logic       l2_load_valid = 1'b0;
  logic       l2_load_ready;
  logic [7:0] l2_load_data = '0;
  logic       l2_dir = 1'b0;
  logic [1:0] l2_mode = MODE_LOGIC;
  logic       l2_en = 1'b1;
  logic [1:0] l2_sin = 2'b00;
  logic [1:0] l2_sout;
  logic       l2_sout_valid;
  logic       l2_cap_valid;
  logic       l2_cap_ready = 1'b0;
  logic [7:0] l2_cap_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign sin = loop ? sout : sin_drv;

  shift_engine #(.WIDTH(8), .LANES(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .dir        (dir),
    .mode       (mode),
    .en         (en),
    .sin        (sin),
    .sout       (sout),
    .sout_valid (sout_valid),
    .cap_valid  (cap_valid),
    .cap_ready  (cap_ready),
    .cap_data   (cap_data)
  );

  shift_engine #(.WIDTH(8), .LANES(2)) dut_l2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (l2_load_valid),
    .load_ready (l2_load_ready),
    .load_data  (l2_load_data),
    .dir        (l2_dir),
    .mode       (l2_mode),
    .en         (l2_en),
    .sin        (l2_sin),
    .sout       (l2_sout),
    .sout_valid (l2_sout_valid),
    .cap_valid  (l2_cap_valid),
    .cap_ready  (l2_cap_ready),
    .cap_data   (l2_cap_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle load handshake on the 8x1 instance; returns with the engine in SHIFT.
  task automatic applyStimulus(input logic [7:0] data, input logic d, input logic [1:0] m);
    load_data  = data;
    dir        = d;
    mode       = m;
    load_valid = 1'b1;
    checkOutput("load_ready_before_load", load_ready, 1);
    tick();
    load_valid = 1'b0;
    checkOutput("sout_valid_after_load", sout_valid, 1);
  endtask

  // Counts cycles until cap_valid; a missing capture shows up as a count of 40.
  task automatic waitCap(input string tag, input int exp_cycles);
    int n = 0;
    while (!cap_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput(tag, n, exp_cycles);
  endtask

  task automatic drainCap();
    cap_ready = 1'b1;
    tick();
    cap_ready = 1'b0;
    checkOutput("idle_after_cap_ready", load_ready, 1);
  endtask

  logic [7:0] exp_a5;
  logic [1:0] exp_l2 [4];
  logic       frozen;

  initial begin
    exp_a5 = 8'hA5;
    exp_l2[0] = 2'b10;
    exp_l2[1] = 2'b00;
    exp_l2[2] = 2'b00;
    exp_l2[3] = 2'b01;

    #2;
    checkOutput("rst_load_ready", load_ready, 1);
    checkOutput("rst_sout_valid", sout_valid, 0);
    checkOutput("rst_cap_valid", cap_valid, 0);
    checkOutput("rst_sout", sout, 0);
    checkOutput("rst_cap_data", cap_data, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Logical right with sout looped back: the word recirculates bit by bit.
    loop = 1'b1;
    en   = 1'b1;
    applyStimulus(8'hA5, 1'b0, MODE_LOGIC);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("loop_sout_%0d", i), sout, exp_a5[i]);
      tick();
    end
    checkOutput("loop_cap_valid", cap_valid, 1);
    checkOutput("loop_cap_data", cap_data, 8'hA5);
    drainCap();
    loop = 1'b0;

    // Two-lane rotate left on the second instance.
    l2_load_data  = 8'h81;
    l2_dir        = 1'b1;
    l2_mode       = MODE_ROT;
    l2_load_valid = 1'b1;
    tick();
    l2_load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rot2_sout_%0d", i), l2_sout, exp_l2[i]);
      tick();
    end
    checkOutput("rot2_cap_valid", l2_cap_valid, 1);
    checkOutput("rot2_cap_data", l2_cap_data, 8'h81);
    l2_cap_ready = 1'b1;
    tick();
    l2_cap_ready = 1'b0;
    checkOutput("rot2_idle", l2_load_ready, 1);

    // Arithmetic right replicates the sign bit; sin is ignored.
    sin_drv = 1'b1;
    applyStimulus(8'h90, 1'b0, MODE_ARITH);
    waitCap("arith_neg_latency", 8);
    checkOutput("arith_neg_data", cap_data, 8'hFF);
    drainCap();
    sin_drv = 1'b0;
    applyStimulus(8'h70, 1'b0, MODE_ARITH);
    waitCap("arith_pos_latency", 8);
    checkOutput("arith_pos_data", cap_data, 8'h00);
    drainCap();

    // Arithmetic left zero-fills even with sin high; reserved mode acts as logical.
    sin_drv = 1'b1;
    applyStimulus(8'h01, 1'b1, MODE_ARITH);
    waitCap("arith_left_latency", 8);
    checkOutput("arith_left_data", cap_data, 8'h00);
    drainCap();
    applyStimulus(8'h00, 1'b1, 2'b11);
    waitCap("reserved_left_latency", 8);
    checkOutput("reserved_left_data", cap_data, 8'hFF);
    drainCap();

    // Enable pattern 1,0,0,1,...: two stalled cycles stretch the run from 8 to 10.
    applyStimulus(8'hA5, 1'b0, MODE_LOGIC);
    tick();
    checkOutput("stall_sout_after_step", sout, 0);
    en = 1'b0;
    tick();
    checkOutput("stall_sout_hold1", sout, 0);
    tick();
    checkOutput("stall_sout_hold2", sout, 0);
    checkOutput("stall_no_cap", cap_valid, 0);
    en = 1'b1;
    waitCap("stall_remaining_steps", 7);
    checkOutput("stall_cap_data", cap_data, 8'hFF);

    // Hold in DONE with a competing load offered: nothing may change.
    load_valid = 1'b1;
    load_data  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("done_cap_valid_%0d", i), cap_valid, 1);
      checkOutput($sformatf("done_cap_data_%0d", i), cap_data, 8'hFF);
      checkOutput($sformatf("done_load_ready_%0d", i), load_ready, 0);
    end
    load_valid = 1'b0;
    drainCap();
    checkOutput("done_released_cap_valid", cap_valid, 0);
    sin_drv = 1'b0;

    // Reset mid-shift abandons the word; a fresh load then runs normally.
    applyStimulus(8'hA5, 1'b0, MODE_LOGIC);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_load_ready", load_ready, 1);
    checkOutput("midrst_sout_valid", sout_valid, 0);
    checkOutput("midrst_cap_valid", cap_valid, 0);
    checkOutput("midrst_sout", sout, 0);
    checkOutput("midrst_cap_data", cap_data, 0);
    tick();
    checkOutput("midrst_hold_cap_valid", cap_valid, 0);
    rst_n = 1'b1;
    frozen = cap_valid;
    checkOutput("midrst_release_cap_valid", frozen, 0);
    loop = 1'b1;
    applyStimulus(8'h3C, 1'b0, MODE_LOGIC);
    waitCap("post_rst_latency", 8);
    checkOutput("post_rst_cap_data", cap_data, 8'h3C);
    drainCap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits; SHALL be >= 2.
REQ-002 Parameter LANES, default 1: bits moved per shift step; SHALL divide WIDTH; STEPS = WIDTH/LANES.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 load_valid  in  1  parallel word offered.
REQ-006 load_ready  out  1  engine can accept a word.
REQ-007 load_data  in  WIDTH  parallel word.
REQ-008 dir  in  1  0 = shift right (toward bit 0), 1 = shift left; sampled on load handshake.
REQ-009 mode  in  2  00 logical, 01 rotate, 10 arithmetic, 11 reserved (treated as logical); sampled on load handshake.
REQ-010 en  in  1  shift-step enable.
REQ-011 sin  in  LANES  serial input lanes.
REQ-012 sout  out  LANES  lanes leaving on the next step.
REQ-013 sout_valid  out  1  sout meaningful this cycle.
REQ-014 cap_valid  out  1  captured word available.
REQ-015 cap_ready  in  1  consumer takes captured word.
REQ-016 cap_data  out  WIDTH  register contents after STEPS steps.

Function
REQ-017 FSM states IDLE, SHIFT, DONE; IDLE -> SHIFT on load_valid & load_ready; SHIFT -> DONE when the final step executes; DONE -> IDLE on cap_ready.
REQ-018 load_ready SHALL be 1 exactly in IDLE; a load handshake writes load_data to the register, latches dir/mode, and sets the step counter to STEPS.
REQ-019 In SHIFT, each cycle with en=1 performs one step and decrements the counter; en=0 holds register, counter and sout unchanged.
REQ-020 Right logical step: q <= {sin, q[WIDTH-1:LANES]}; left logical step: q <= {q[WIDTH-LANES-1:0], sin}.
REQ-021 Rotate step: the lanes shifted out re-enter at the opposite end; sin ignored; after STEPS steps register equals the loaded word.
REQ-022 Arithmetic right step: vacated LANES MSBs filled with q[WIDTH-1]; arithmetic left behaves as logical left with zero fill; sin ignored.
REQ-023 sout SHALL be q[LANES-1:0] when dir=0 and q[WIDTH-1:WIDTH-LANES] when dir=1, combinational from the register; sout_valid = (state==SHIFT).
REQ-024 Latency: handshake at cycle T, first step no earlier than T+1, cap_valid rises the cycle after the STEPS-th enabled step.
REQ-025 cap_valid = (state==DONE); cap_data = register, stable until cap_ready; load_valid ignored outside IDLE.
REQ-026 Step counter width SHALL be clog2(STEPS+1); no wrap: counter never decrements below 0.

Reset
REQ-027 rst_n low SHALL, asynchronously, force state IDLE, register 0, counter 0, latched dir/mode 0; outputs: load_ready 1, sout_valid 0, cap_valid 0, sout 0, cap_data 0.
REQ-028 rst_n assertion mid-SHIFT or in DONE SHALL abandon the word without a cap_valid pulse; first handshake possible on the first edge after release.

Structure
REQ-029 Mode encodings (MODE_LOGIC, MODE_ROT, MODE_ARITH) and the FSM state enum SHALL live in shared package shift_pkg.
REQ-030 The one-step datapath (register, dir, mode, sin -> next register) SHALL be sub-module shift_step, combinational, parametrised by WIDTH and LANES.

Verification
REQ-031 WIDTH=8, LANES=1, logical right, load 0xA5, sout looped to sin, en=1: sout = 1,0,1,0,0,1,0,1; cap_data = 0xA5 after 8 steps.
REQ-032 WIDTH=8, LANES=2, rotate left, load 0x81: sout = 2'b10, 00, 00, 01; cap_data = 0x81.
REQ-033 WIDTH=8, LANES=1, arithmetic right, load 0x90, sin=0: cap_data = 0xFF; same with load 0x70 -> 0x00.
REQ-034 en toggled 1,0,0,1 during SHIFT: register and sout frozen on en=0 cycles; cap_valid delayed by exactly 2 cycles.
REQ-035 cap_ready held 0 for 5 cycles in DONE: cap_valid and cap_data stable, load_ready 0, load_valid ignored; cap_ready=1 -> IDLE next edge.
REQ-036 rst_n pulsed low after 3 of 8 steps: all outputs at reset values immediately, no cap_valid; new load 0x3C afterwards completes normally.
